// File: rtl/mbc_pkg.sv
// Shared constants, save-state word layout and stream FSM states for the
// generic banked ROM/RAM mapper.
package mbc_pkg;

  // Register regions: RAM enable and RAM bank decode on cart_addr[14:13],
  // ROM bank halves decode on cart_addr[14:12].
  localparam logic [1:0] REG_RAMEN   = 2'b00;
  localparam logic [2:0] REG_ROMLO   = 3'b010;
  localparam logic [2:0] REG_ROMHI   = 3'b011;
  localparam logic [1:0] REG_RAMBANK = 2'b10;

  localparam logic [3:0] RAMEN_KEY = 4'hA;

  localparam int unsigned SS_WORD_W = 16;
  localparam int unsigned SS_IDX_W  = 1;
  localparam logic [SS_IDX_W-1:0] SS_IDX_ROM = 1'b0;
  localparam logic [SS_IDX_W-1:0] SS_IDX_RAM = 1'b1;

  typedef enum logic [1:0] {
    SS_IDLE = 2'd0,
    SS_W0   = 2'd1,
    SS_W1   = 2'd2
  } ss_state_e;

  typedef struct packed {
    logic       ram_en;
    logic [6:0] rsvd;
    logic [7:0] ram_bank;
  } ss_word1_t;

endpackage

// File: rtl/mbc_ss_stream.sv
// Two-word valid/ready save-state serializer with snapshot on entry, plus the
// load word sequencer shared by the banked mappers.
module mbc_ss_stream
  import mbc_pkg::*;
#(
  parameter int unsigned N_WORDS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               save_req_i,
  input  logic                               save_ready_i,
  input  logic [N_WORDS-1:0][SS_WORD_W-1:0]  words_i,
  input  logic                               load_valid_i,
  output logic [SS_WORD_W-1:0]               save_data_o,
  output logic                               save_valid_o,
  output logic                               load_we_o,
  output logic [SS_IDX_W-1:0]                load_idx_o,
  output logic                               busy_o
);

  ss_state_e             state_q, state_d;
  logic [SS_WORD_W-1:0]  data_q, data_d;
  logic [SS_WORD_W-1:0]  snap_q, snap_d;
  logic                  valid_q, valid_d;
  logic [SS_IDX_W-1:0]   idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SS_IDLE;
      data_q  <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  // Loads are only accepted while no save is in flight; saves only start
  // when no load sequence is open or arriving.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    snap_d    = snap_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    load_we_o = load_valid_i && (state_q == SS_IDLE);

    if (load_we_o) begin
      idx_d = (idx_q == SS_IDX_W'(N_WORDS - 1)) ? '0 : idx_q + SS_IDX_W'(1);
    end

    unique case (state_q)
      SS_IDLE: begin
        if (save_req_i && !load_valid_i && (idx_q == '0)) begin
          state_d = SS_W0;
          valid_d = 1'b1;
          data_d  = words_i[0];
          snap_d  = words_i[1];
        end
      end
      SS_W0: begin
        if (valid_q && save_ready_i) begin
          state_d = SS_W1;
          data_d  = snap_q;
        end
      end
      SS_W1: begin
        if (valid_q && save_ready_i) begin
          state_d = SS_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = SS_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign save_data_o  = data_q;
  assign save_valid_o = valid_q;
  assign load_idx_o   = idx_q;
  assign busy_o       = (idx_q != '0) || (state_q != SS_IDLE);

endmodule

// File: rtl/mbc_banked_core.sv
// Generic banked ROM/RAM cartridge controller with configurable bank widths,
// selectable bank-0 remap and a handshaked save-state stream.
module mbc_banked_core
  import mbc_pkg::*;
#(
  parameter int unsigned ROM_BANK_W = 9,
  parameter int unsigned RAM_BANK_W = 4,
  parameter int unsigned ZERO_REMAP = 0,
  parameter int unsigned SS_WORDS   = 2
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_cpu,
  input  logic                    enable,
  input  logic [14:0]             cart_addr,
  input  logic                    cart_a15,
  input  logic                    cart_wr,
  input  logic [7:0]              cart_di,
  input  logic                    has_ram,
  input  logic [ROM_BANK_W-1:0]   rom_mask,
  input  logic [RAM_BANK_W-1:0]   ram_mask,
  output logic [ROM_BANK_W+13:0]  mbc_addr,
  output logic [RAM_BANK_W+12:0]  cram_addr,
  output logic                    ram_enabled,
  input  logic                    ss_load_valid,
  input  logic [15:0]             ss_load_data,
  input  logic                    ss_save_req,
  output logic [15:0]             ss_save_data,
  output logic                    ss_save_valid,
  input  logic                    ss_save_ready,
  output logic                    ss_busy
);

  logic [ROM_BANK_W-1:0] rom_bank_q, rom_bank_d;
  logic [RAM_BANK_W-1:0] ram_bank_q, ram_bank_d;
  logic                  ram_en_q, ram_en_d;
  logic [15:0]           rom16;
  logic                  cpu_we;
  logic                  load_we;
  logic [SS_IDX_W-1:0]   load_idx;
  logic [15:0]           ss_data;
  logic                  ss_valid;
  logic                  ss_busy_int;
  ss_word1_t             word1;
  logic [SS_WORDS-1:0][SS_WORD_W-1:0] ss_words;
  logic [ROM_BANK_W-1:0] eff_bank;

  assign cpu_we = enable & ce_cpu & cart_wr & ~cart_a15;

  always_comb begin
    word1          = '0;
    word1.ram_en   = ram_en_q;
    word1.ram_bank = 8'(ram_bank_q);
  end

  assign ss_words[0] = 16'(rom_bank_q);
  assign ss_words[1] = word1;

  mbc_ss_stream #(
    .N_WORDS (SS_WORDS)
  ) u_ss (
    .clk          (clk_sys),
    .rst          (reset),
    .save_req_i   (enable & ss_save_req),
    .save_ready_i (ss_save_ready),
    .words_i      (ss_words),
    .load_valid_i (enable & ss_load_valid),
    .save_data_o  (ss_data),
    .save_valid_o (ss_valid),
    .load_we_o    (load_we),
    .load_idx_o   (load_idx),
    .busy_o       (ss_busy_int)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_bank_q <= ROM_BANK_W'(1);
      ram_bank_q <= '0;
      ram_en_q   <= 1'b0;
    end else begin
      rom_bank_q <= rom_bank_d;
      ram_bank_q <= ram_bank_d;
      ram_en_q   <= ram_en_d;
    end
  end

  // A save-state load word wins over a CPU write in the same cycle.
  always_comb begin
    rom_bank_d = rom_bank_q;
    ram_bank_d = ram_bank_q;
    ram_en_d   = ram_en_q;
    rom16      = 16'(rom_bank_q);
    if (load_we) begin
      if (load_idx == SS_IDX_ROM) begin
        rom_bank_d = ss_load_data[ROM_BANK_W-1:0];
      end else begin
        ram_bank_d = ss_load_data[RAM_BANK_W-1:0];
        ram_en_d   = ss_load_data[15];
      end
    end else if (cpu_we) begin
      if (cart_addr[14:13] == REG_RAMEN) begin
        ram_en_d = (cart_di[3:0] == RAMEN_KEY);
      end else if (cart_addr[14:12] == REG_ROMLO) begin
        rom16[7:0] = cart_di;
        rom_bank_d = rom16[ROM_BANK_W-1:0];
      end else if (cart_addr[14:12] == REG_ROMHI) begin
        if (ROM_BANK_W > 8) begin
          rom16[15:8] = cart_di;
          rom_bank_d  = rom16[ROM_BANK_W-1:0];
        end
      end else if (cart_addr[14:13] == REG_RAMBANK) begin
        ram_bank_d = cart_di[RAM_BANK_W-1:0];
      end
    end
  end

  assign eff_bank = ((ZERO_REMAP != 0) && (rom_bank_q == '0)) ? ROM_BANK_W'(1) : rom_bank_q;

  assign mbc_addr      = !enable       ? '0 :
                         cart_addr[14] ? {eff_bank & rom_mask, cart_addr[13:0]} :
                                         {ROM_BANK_W'(0), cart_addr[13:0]};
  assign cram_addr     = enable ? {ram_bank_q & ram_mask, cart_addr[12:0]} : '0;
  assign ram_enabled   = enable & has_ram & ram_en_q;
  assign ss_save_data  = enable ? ss_data : '0;
  assign ss_save_valid = enable & ss_valid;
  assign ss_busy       = enable & ss_busy_int;

endmodule

// File: tb/tb_mbc_banked_core.sv
// Directed bench for mbc_banked_core: queue-based register/save-state model
// compared every cycle, plus literal expectations taken from hand calculation.
module tb_mbc_banked_core;

  logic        clk_sys = 1'b0;
  logic        reset, ce_cpu, enable, cart_a15, cart_wr, has_ram;
  logic [14:0] cart_addr;
  logic [7:0]  cart_di;
  logic [8:0]  rom_mask;
  logic [3:0]  ram_mask;
  logic        ss_load_valid, ss_save_req, ss_save_ready;
  logic [15:0] ss_load_data;

  logic [22:0] mbc_addr, z1_mbc_addr;
  logic [16:0] cram_addr, z1_cram_addr;
  logic        ram_enabled, z1_ram_enabled;
  logic [15:0] ss_save_data, z1_ss_save_data;
  logic        ss_save_valid, z1_ss_save_valid, ss_busy, z1_ss_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk_sys = ~clk_sys;

  mbc_banked_core #(.ZERO_REMAP(0)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .enable(enable),
    .cart_addr(cart_addr), .cart_a15(cart_a15), .cart_wr(cart_wr), .cart_di(cart_di),
    .has_ram(has_ram), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .mbc_addr(mbc_addr), .cram_addr(cram_addr), .ram_enabled(ram_enabled),
    .ss_load_valid(ss_load_valid), .ss_load_data(ss_load_data), .ss_save_req(ss_save_req),
    .ss_save_data(ss_save_data), .ss_save_valid(ss_save_valid),
    .ss_save_ready(ss_save_ready), .ss_busy(ss_busy));

  mbc_banked_core #(.ZERO_REMAP(1)) dut_z1 (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .enable(enable),
    .cart_addr(cart_addr), .cart_a15(cart_a15), .cart_wr(cart_wr), .cart_di(cart_di),
    .has_ram(has_ram), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .mbc_addr(z1_mbc_addr), .cram_addr(z1_cram_addr), .ram_enabled(z1_ram_enabled),
    .ss_load_valid(ss_load_valid), .ss_load_data(ss_load_data), .ss_save_req(ss_save_req),
    .ss_save_data(z1_ss_save_data), .ss_save_valid(z1_ss_save_valid),
    .ss_save_ready(ss_save_ready), .ss_busy(z1_ss_busy));

  // Behavioural model: bank registers as integers, save stream as a word queue.
  int          m_rom, m_ram, m_en, m_idx;
  logic [15:0] m_q[$];

  always @(posedge clk_sys) begin
    bit saving, ld, wr;
    if (reset) begin
      m_rom = 1; m_ram = 0; m_en = 0; m_idx = 0;
      m_q.delete();
    end else begin
      saving = (m_q.size() != 0);
      ld = enable && ss_load_valid && !saving;
      wr = enable && ce_cpu && cart_wr && !cart_a15 && !ld;
      if (saving && ss_save_ready) void'(m_q.pop_front());
      else if (!saving && enable && ss_save_req && m_idx == 0 && !ss_load_valid) begin
        m_q.push_back(16'(m_rom));
        m_q.push_back(16'((m_en << 15) | m_ram));
      end
      if (ld) begin
        if (m_idx == 0) m_rom = ss_load_data & 16'h01FF;
        else begin
          m_ram = ss_load_data & 16'h000F;
          m_en  = ss_load_data[15];
        end
        m_idx = (m_idx + 1) % 2;
      end else if (wr) begin
        case (cart_addr[14:12])
          3'd0, 3'd1: m_en  = (cart_di[3:0] == 4'hA) ? 1 : 0;
          3'd2:       m_rom = (m_rom & 'h100) | cart_di;
          3'd3:       m_rom = (m_rom & 'h0FF) | ((cart_di & 1) << 8);
          3'd4, 3'd5: m_ram = cart_di & 'hF;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_mbc(bit remap);
    int eff;
    eff = (remap && m_rom == 0) ? 1 : m_rom;
    if (!enable) return 32'd0;
    if (cart_addr[14]) return 32'(((eff & rom_mask) << 14) | cart_addr[13:0]);
    return 32'(cart_addr[13:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (cmp_on) begin
      chk("mbc_addr", 32'(mbc_addr), exp_mbc(1'b0));
      chk("mbc_addr_remap", 32'(z1_mbc_addr), exp_mbc(1'b1));
      chk("cram_addr", 32'(cram_addr), enable ? 32'(((m_ram & ram_mask) << 13) | cart_addr[12:0]) : 32'd0);
      chk("ram_enabled", 32'(ram_enabled), 32'(enable && has_ram && m_en != 0));
      chk("ss_save_valid", 32'(ss_save_valid), 32'(enable && m_q.size() != 0));
      chk("ss_busy", 32'(ss_busy), 32'(enable && (m_idx != 0 || m_q.size() != 0)));
      if (enable && m_q.size() != 0) chk("ss_save_data", 32'(ss_save_data), 32'(m_q[0]));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cart_addr = a[14:0]; cart_a15 = a[15]; cart_di = d; cart_wr = 1'b1;
    tick();
    cart_wr = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a);
    cart_addr = a[14:0]; cart_a15 = a[15];
    @(negedge clk_sys);
    #1;
  endtask

  initial begin
    reset = 1'b1; ce_cpu = 1'b1; enable = 1'b1; cart_a15 = 1'b0; cart_wr = 1'b0;
    has_ram = 1'b1; cart_addr = '0; cart_di = '0; rom_mask = 9'h1FF; ram_mask = 4'hF;
    ss_load_valid = 1'b0; ss_save_req = 1'b0; ss_save_ready = 1'b0; ss_load_data = '0;
    tick(); tick();
    reset = 1'b0; cmp_on = 1'b1;

    peek(16'h4123);
    chk("lit_reset_mbc", 32'(mbc_addr), 32'h04123);
    chk("lit_reset_ramen", 32'(ram_enabled), 32'd0);
    chk("lit_reset_valid", 32'(ss_save_valid), 32'd0);

    cpu_wr(16'h2000, 8'h00);
    peek(16'h4000);
    chk("lit_bank0_noremap", 32'(mbc_addr), 32'h00000);
    chk("lit_bank0_remap", 32'(z1_mbc_addr), 32'h04000);

    cpu_wr(16'h3000, 8'h01);
    cpu_wr(16'h2000, 8'h05);
    peek(16'h4000);
    chk("lit_bank105", 32'(mbc_addr), 32'h414000);
    rom_mask = 9'h0FF;
    peek(16'h4000);
    chk("lit_bank_masked", 32'(mbc_addr), 32'h014000);
    rom_mask = 9'h1FF;

    // Writes that must be ignored: CE low, and A15 high (RAM space).
    ce_cpu = 1'b0; cpu_wr(16'h2000, 8'h99); ce_cpu = 1'b1;
    cpu_wr(16'hA000, 8'h77);
    peek(16'h4000);
    chk("lit_ignored_writes", 32'(mbc_addr), 32'h414000);

    cpu_wr(16'h0000, 8'h0A);
    cpu_wr(16'h4000, 8'h03);
    ram_mask = 4'h1;
    peek(16'hA010);
    chk("lit_ramen_on", 32'(ram_enabled), 32'd1);
    chk("lit_cram", 32'(cram_addr), 32'h02010);
    cpu_wr(16'h0000, 8'h0B);
    peek(16'hA010);
    chk("lit_ramen_off", 32'(ram_enabled), 32'd0);
    ram_mask = 4'hF;

    enable = 1'b0;
    cpu_wr(16'h2000, 8'h42);
    peek(16'h4000);
    chk("lit_disabled_mbc", 32'(mbc_addr), 32'd0);
    enable = 1'b1;

    // Save with ready low for three cycles; a RAM bank write mid-save must not
    // change the captured word1.
    cpu_wr(16'h4000, 8'h02);
    cpu_wr(16'h0000, 8'h0A);
    ss_save_req = 1'b1; tick(); ss_save_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) cpu_wr(16'h4000, 8'h05); else tick();
      chk("lit_word0", 32'(ss_save_data), 32'h0105);
      chk("lit_word0_valid", 32'(ss_save_valid), 32'd1);
    end
    ss_save_ready = 1'b1; tick();
    chk("lit_word1", 32'(ss_save_data), 32'h8002);
    tick();
    ss_save_ready = 1'b0;
    chk("lit_save_done", 32'(ss_save_valid), 32'd0);

    // Load with a concurrent CPU write; a save request mid-load is ignored.
    ss_load_valid = 1'b1; ss_load_data = 16'h0033;
    cart_addr = 15'h2000; cart_a15 = 1'b0; cart_di = 8'h44; cart_wr = 1'b1;
    tick();
    ss_load_valid = 1'b0; cart_wr = 1'b0;
    peek(16'h4000);
    chk("lit_load0_mbc", 32'(mbc_addr), 32'h0CC000);
    chk("lit_load_busy", 32'(ss_busy), 32'd1);
    ss_save_req = 1'b1; tick(); ss_save_req = 1'b0;
    chk("lit_load_nosave", 32'(ss_save_valid), 32'd0);
    ss_load_valid = 1'b1; ss_load_data = 16'h0001; tick(); ss_load_valid = 1'b0;
    peek(16'hA000);
    chk("lit_load1_busy", 32'(ss_busy), 32'd0);
    chk("lit_load1_ramen", 32'(ram_enabled), 32'd0);
    chk("lit_load1_cram", 32'(cram_addr), 32'h02000);

    // Reset during W1 aborts the stream and restores defaults.
    ss_save_req = 1'b1; tick(); ss_save_req = 1'b0;
    ss_save_ready = 1'b1; tick(); ss_save_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    peek(16'h4000);
    chk("lit_rst_valid", 32'(ss_save_valid), 32'd0);
    chk("lit_rst_mbc", 32'(mbc_addr), 32'h04000);
    ss_save_req = 1'b1; tick(); ss_save_req = 1'b0;
    chk("lit_restart_word0", 32'(ss_save_data), 32'h0001);
    chk("lit_restart_valid", 32'(ss_save_valid), 32'd1);
    ss_save_ready = 1'b1; tick(); tick(); ss_save_ready = 1'b0;
    tick();

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbc_banked_core.md
Name: mbc_banked_core

Overview:
- Parametrised successor of the per-mapper banking logic: one generic banked ROM/RAM controller.
- ROM and RAM bank widths are configurable, and the bank-0 remap rule is selectable.
- Adds a handshaked savestate stream: registers are saved and restored as sequenced 16-bit words instead of a flat bus.
- Sits beside the existing mapper instances behind the mapper mux; selected by `enable`.

Parameters:
- ROM_BANK_W, 9, ROM bank register width (1..16); mbc_addr width = ROM_BANK_W+14.
- RAM_BANK_W, 4, RAM bank register width (1..8); cram_addr width = RAM_BANK_W+13.
- ZERO_REMAP, 0, 1 = a ROM bank value of 0 in the 0x4000 window maps to bank 1 (MBC1-style); 0 = bank 0 allowed (MBC5-style).
- SS_WORDS, 2, number of savestate words (fixed at 2; a parameter only for chain sizing).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce_cpu  in  1  CPU clock enable; qualifies cart writes.
- enable  in  1  mapper selected; when 0, all outputs are 0 and writes are ignored.
- cart_addr  in  15  CPU address [14:0].
- cart_a15  in  1  CPU address bit 15.
- cart_wr  in  1  CPU write strobe.
- cart_di  in  8  CPU write data.
- has_ram  in  1  cartridge has RAM.
- rom_mask  in  ROM_BANK_W  ROM bank mask.
- ram_mask  in  RAM_BANK_W  RAM bank mask.
- mbc_addr  out  ROM_BANK_W+14  ROM byte address.
- cram_addr  out  RAM_BANK_W+13  cart RAM byte address.
- ram_enabled  out  1  RAM access permitted.
- ss_load_valid  in  1  savestate load word strobe.
- ss_load_data  in  16  savestate load word.
- ss_save_req  in  1  start savestate stream (pulse).
- ss_save_data  out  16  savestate word.
- ss_save_valid  out  1  ss_save_data valid.
- ss_save_ready  in  1  consumer accepts the word.
- ss_busy  out  1  save or load sequence in progress.

Behaviour:
- Register write condition: enable & ce_cpu & cart_wr & ~cart_a15. Writes decode on cart_addr[14:12]:
  - 0x0000-0x1FFF: ram_en <= (cart_di[3:0]==4'hA).
  - 0x2000-0x2FFF: rom_bank[7:0] <= cart_di.
  - 0x3000-0x3FFF: rom_bank[ROM_BANK_W-1:8] <= cart_di low bits. Ignored when ROM_BANK_W<=8.
  - 0x4000-0x5FFF: ram_bank <= cart_di[RAM_BANK_W-1:0].
  - 0x6000-0x7FFF: no effect.
- Reset values: rom_bank=1, ram_bank=0, ram_en=0. Also on reset: save FSM to IDLE, load index=0, ss_save_valid=0, ss_busy=0.
- Output timing: outputs are combinational from the registers. A write takes effect the cycle after the qualifying clk_sys edge.
- ROM mapping:
  - eff = (ZERO_REMAP && rom_bank==0) ? 1 : rom_bank.
  - cart_addr[14]=0: mbc_addr = {0, cart_addr[13:0]}.
  - cart_addr[14]=1: mbc_addr = {eff & rom_mask, cart_addr[13:0]}. The mask is applied after the remap.
- RAM mapping: cram_addr = {ram_bank & ram_mask, cart_addr[12:0]}; ram_enabled = enable & has_ram & ram_en.
- Save FSM, states IDLE, W0, W1:
  - IDLE -> W0 on ss_save_req (only when not loading).
  - W0 presents word0 = rom_bank zero-extended to 16 bits, with valid=1.
  - W0 -> W1 on valid&ready.
  - W1 presents word1 = {ram_en, 7'b0, ram_bank zero-extended to 8 bits}.
  - W1 -> IDLE on valid&ready.
  - ss_save_valid is registered and held, with data stable, until ready.
  - ss_save_req while not IDLE is ignored.
- Load sequence:
  - Each ss_load_valid writes word[idx] into the registers; idx increments and wraps to 0 after word1.
  - ss_busy is 1 while idx!=0.
  - ss_load_valid arriving while the save FSM is not IDLE is ignored.
  - A load takes priority over a simultaneous CPU write; that CPU write is dropped.
- Save snapshot: the registers are snapshotted on entry to W0, so a CPU write during a save does not change the words already captured.
- Reset mid-sequence aborts immediately (valid drops the cycle after reset is sampled) and restores the reset values.
- Unused upper savestate bits are written as 0 and ignored on load.

Decomposition:
- Package mbc_pkg holds:
  - address region constants (REG_RAMEN, REG_ROMLO, REG_ROMHI, REG_RAMBANK);
  - RAMEN_KEY = 4'hA;
  - the save FSM state enum;
  - SS word index constants.
- One sub-module, mbc_ss_stream: a generic N-word valid/ready serializer and load sequencer, reused by later mappers.

Test Plan:
- Reset, then read 0x4123 -> mbc_addr=0x04123 (bank 1), ram_enabled=0, ss_save_valid=0.
- Write 0x2000<=0x00 with ZERO_REMAP=0, then ZERO_REMAP=1 -> 0x4000 maps to 0x00000 and 0x04000 respectively. Write 0x3000<=1, 0x2000<=0x05, rom_mask=0x1FF -> mbc_addr for 0x4000 = 0x414000.
- Write 0x0000<=0x0A, has_ram=1, 0x4000<=0x3, ram_mask=0x1 -> ram_enabled=1, cram_addr for A010 = 0x02010. Then write 0x0000<=0x0B -> ram_enabled=0.
- rom_bank=0x105, ram_bank=2, ram_en=1; ss_save_req with ready held low for 3 cycles -> word0=0x0105 held stable; then ready=1 -> word1=0x8002, FSM returns to IDLE.
- Load words 0x0033, 0x0001 with a concurrent CPU write to 0x2000 -> rom_bank=0x033, ram_bank=1, ram_en=0, CPU write dropped, ss_busy high between the two words.
- Assert reset during W1 -> next cycle valid=0, rom_bank=1, a new ss_save_req starts at W0.
